// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame FSM states, parity
// modes and default widths used by the frame controller and edge_bit_counter.
package uart_rx_pkg;

    localparam int unsigned PRESCALE_W = 6;
    localparam int unsigned DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_data_sampling.sv
// Mid-bit oversampler: captures RX_IN at edge_cnt H-1, H and H+1 (H = Prescale/2)
// and registers the majority as samp_bit on the H+1 edge.
module data_sampling
    import uart_rx_pkg::*;
#(
    parameter int unsigned WIDTH = PRESCALE_W
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             enable,
    input  logic             RX_IN,
    input  logic [WIDTH-1:0] Prescale,
    input  logic [WIDTH-1:0] edge_cnt,
    output logic             samp_bit
);

    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] pt_early;
    logic [WIDTH-1:0] pt_late;

    logic [2:0] samples_q, samples_d;
    logic       samp_bit_q, samp_bit_d;

    assign half     = Prescale >> 1;
    assign pt_early = half - 1'b1;
    assign pt_late  = half + 1'b1;

    always_comb begin
        samples_d  = samples_q;
        samp_bit_d = samp_bit_q;
        if (enable) begin
            if (edge_cnt == pt_early) begin
                samples_d[0] = RX_IN;
            end
            if (edge_cnt == half) begin
                samples_d[1] = RX_IN;
            end
            // Vote with the live third sample so samp_bit is ready from H+2.
            if (edge_cnt == pt_late) begin
                samples_d[2] = RX_IN;
                samp_bit_d   = majority3({RX_IN, samples_q[1:0]});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            samples_q  <= '0;
            samp_bit_q <= 1'b0;
        end else begin
            samples_q  <= samples_d;
            samp_bit_q <= samp_bit_d;
        end
    end

    assign samp_bit = samp_bit_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detect, counter enable, LSB-first
// deserialisation, parity/stop checking and one-cycle data_valid delivery.
module uart_rx_frame_ctrl
    import uart_rx_pkg::rx_state_e, uart_rx_pkg::IDLE, uart_rx_pkg::START,
           uart_rx_pkg::DATA, uart_rx_pkg::PARITY, uart_rx_pkg::STOP,
           uart_rx_pkg::PAR_ODD, uart_rx_pkg::PRESCALE_W;
#(
    parameter int unsigned WIDTH      = PRESCALE_W,
    parameter int unsigned DATA_WIDTH = uart_rx_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [WIDTH-1:0]      Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [WIDTH-1:0]      edge_cnt,
    input  logic [3:0]            bit_cnt,
    output logic                  cnt_enable,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    rx_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic             samp_bit;
    logic [WIDTH-1:0] half;
    logic             bit_end;
    logic             shift_pt;
    logic             last_data;
    logic             parity_exp;

    assign cnt_enable = (state_q != IDLE);

    data_sampling #(
        .WIDTH (WIDTH)
    ) u_data_sampling (
        .clk      (clk),
        .RST      (RST),
        .enable   (cnt_enable),
        .RX_IN    (RX_IN),
        .Prescale (Prescale),
        .edge_cnt (edge_cnt),
        .samp_bit (samp_bit)
    );

    assign half       = Prescale >> 1;
    assign bit_end    = (edge_cnt == Prescale - 1'b1);
    assign shift_pt   = (edge_cnt == half + 2'd2);
    assign last_data  = (bit_cnt == 4'(DATA_WIDTH));
    assign parity_exp = (PAR_TYP == PAR_ODD) ? ~^shift_q : ^shift_q;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;

        unique case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d   = START;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = samp_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                // Shift-right with insert at the MSB so the first bit ends at bit 0.
                if (shift_pt) begin
                    shift_d                 = shift_q >> 1;
                    shift_d[DATA_WIDTH-1]   = samp_bit;
                end
                if (bit_end && last_data) begin
                    state_d = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_err_d = (samp_bit != parity_exp);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    stp_err_d = ~samp_bit;
                    if (samp_bit && !par_err_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl with a behavioural edge_bit_counter.
module tb_uart_rx_frame_ctrl;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] edge_cnt = '0;
    logic [3:0] bit_cnt  = '0;
    logic       cnt_enable;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx_frame_ctrl #(
        .WIDTH      (6),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .cnt_enable (cnt_enable),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Upstream edge_bit_counter behaviour: held at zero while disabled.
    always @(posedge clk) begin
        if (RST || !cnt_enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == Prescale - 6'd1) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 6'd1;
        end
    end

    typedef struct {
        logic [7:0] data;
        int         cycle;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            check_val("valid_has_expect", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("p_data", {24'd0, P_DATA}, {24'd0, e.data});
                check_val("valid_cycle", cyc, e.cycle);
            end
        end
    end

    function automatic int frame_len();
        return 2 + DW + int'(PAR_EN);
    endfunction

    function automatic logic par_of(input logic [7:0] d);
        return PAR_TYP ? ~^d : ^d;
    endfunction

    // Call aligned to posedge+1; E0 is the following posedge.
    task automatic expect_frame(input logic [7:0] data, input int lag);
        exp_t e;
        e.data  = data;
        e.cycle = cyc + 1 + frame_len() * int'(Prescale) + lag;
        sb_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par_bit,
                              input logic stop_bit, input int nbits);
        logic [11:0] bits;
        int k;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[1+i] = data[i];
        k = 1 + DW;
        if (PAR_EN) begin
            bits[k] = par_bit;
            k++;
        end
        bits[k] = stop_bit;
        for (int i = 0; i < nbits; i++) begin
            RX_IN = bits[i];
            repeat (int'(Prescale)) @(posedge clk);
            #1;
            if (i == 0) check_val("flags_clear_on_start", {30'd0, par_err, stp_err}, 32'd0);
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        RX_IN    = 1'b1;
        RST      = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_cnt_enable", 32'(cnt_enable), 32'd0);
        check_val("rst_p_data", {24'd0, P_DATA}, 32'd0);
        check_val("rst_data_valid", 32'(data_valid), 32'd0);
        check_val("rst_errs", {30'd0, par_err, stp_err}, 32'd0);
        RST = 1'b0;
        idle(4);
        check_val("idle_cnt_enable", 32'(cnt_enable), 32'd0);

        // Good frame 0xA5, even parity, Prescale 8
        expect_frame(8'hA5, 0);
        send_frame(8'hA5, par_of(8'hA5), 1'b1, frame_len());
        idle(4);
        check_val("good_p_data", {24'd0, P_DATA}, 32'hA5);
        check_val("good_errs", {30'd0, par_err, stp_err}, 32'd0);

        // Start glitch: two low cycles only
        RX_IN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        RX_IN = 1'b1;
        check_val("glitch_in_start", 32'(cnt_enable), 32'd1);
        repeat (int'(Prescale)) @(posedge clk);
        #1;
        check_val("glitch_back_idle", 32'(cnt_enable), 32'd0);
        check_val("glitch_p_data", {24'd0, P_DATA}, 32'hA5);
        check_val("glitch_errs", {30'd0, par_err, stp_err}, 32'd0);
        idle(4);

        // Parity error: 0x3C with the wrong parity bit
        send_frame(8'h3C, ~par_of(8'h3C), 1'b1, frame_len());
        idle(4);
        check_val("perr_par_err", 32'(par_err), 32'd1);
        check_val("perr_stp_err", 32'(stp_err), 32'd0);
        check_val("perr_p_data", {24'd0, P_DATA}, 32'hA5);

        // Odd parity good frame clears the sticky parity error
        PAR_TYP = 1'b1;
        expect_frame(8'h07, 0);
        send_frame(8'h07, par_of(8'h07), 1'b1, frame_len());
        idle(4);
        check_val("odd_par_err", 32'(par_err), 32'd0);
        check_val("odd_p_data", {24'd0, P_DATA}, 32'h07);

        // Stop error at Prescale 16, no parity
        PAR_TYP  = 1'b0;
        PAR_EN   = 1'b0;
        Prescale = 6'd16;
        send_frame(8'h81, 1'b0, 1'b0, frame_len());
        check_val("serr_before_end", 32'(stp_err), 32'd0);
        RX_IN = 1'b1;
        @(posedge clk);
        #1;
        check_val("serr_stp_err", 32'(stp_err), 32'd1);
        check_val("serr_par_err", 32'(par_err), 32'd0);
        check_val("serr_p_data", {24'd0, P_DATA}, 32'h07);
        idle(4);
        expect_frame(8'h42, 0);
        send_frame(8'h42, 1'b0, 1'b1, frame_len());
        idle(4);
        check_val("p16_p_data", {24'd0, P_DATA}, 32'h42);
        check_val("p16_errs", {30'd0, par_err, stp_err}, 32'd0);

        // Reset during data bit 4
        Prescale = 6'd8;
        PAR_EN   = 1'b1;
        send_frame(8'h5A, par_of(8'h5A), 1'b1, 5);
        check_val("mid_cnt_enable", 32'(cnt_enable), 32'd1);
        RST   = 1'b1;
        RX_IN = 1'b1;
        @(posedge clk);
        #1;
        check_val("mrst_cnt_enable", 32'(cnt_enable), 32'd0);
        check_val("mrst_p_data", {24'd0, P_DATA}, 32'd0);
        check_val("mrst_data_valid", 32'(data_valid), 32'd0);
        check_val("mrst_errs", {30'd0, par_err, stp_err}, 32'd0);
        RST = 1'b0;
        idle(4);
        expect_frame(8'h5A, 0);
        send_frame(8'h5A, par_of(8'h5A), 1'b1, frame_len());
        idle(4);
        check_val("post_rst_p_data", {24'd0, P_DATA}, 32'h5A);

        // Back-to-back; the second start is seen one IDLE cycle late
        PAR_EN = 1'b0;
        expect_frame(8'h01, 0);
        send_frame(8'h01, 1'b0, 1'b1, frame_len());
        expect_frame(8'hFE, 1);
        send_frame(8'hFE, 1'b0, 1'b1, frame_len());
        idle(8);
        check_val("b2b_p_data", {24'd0, P_DATA}, 32'hFE);

        idle(20);
        check_val("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
